// File: rtl/tx_frame_header_inserter.sv
`default_nettype none
// ============================================================================
// Module   : tx_frame_header_inserter
// Purpose  : Prepends one header beat (connection id, declared byte count,
//            per-connection sequence number) to every packet of the muxed TX
//            stream. It also compares the actual keep-byte count of each packet
//            against the declared byte count and flags any mismatch.
// Ports    : clk, resetn (async, active-low)
//            s_tx_*        upstream packet stream with id/byte_num sideband
//            m_tx_*        framed downstream stream (single register stage)
//            seq_clear     pulse that zeroes all sequence counters
//            len_err       one-cycle pulse on a byte-count mismatch
//            len_err_count saturating count of mismatches
// Note     : DATA_WIDTH*8 must be at least 32+SEQ_WIDTH.
// Revision : 1.0 - initial release
// ============================================================================
module tx_frame_header_inserter #(
  parameter int DATA_WIDTH = 16,
  parameter int SEQ_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [DATA_WIDTH*8-1:0] s_tx_data,
  input  logic [DATA_WIDTH-1:0]   s_tx_keep,
  input  logic [3:0]              s_tx_connection_id,
  input  logic [12:0]             s_tx_byte_num,
  input  logic                    s_tx_last,
  input  logic                    s_tx_valid,
  output logic                    s_tx_ready,
  output logic [DATA_WIDTH*8-1:0] m_tx_data,
  output logic [DATA_WIDTH-1:0]   m_tx_keep,
  output logic                    m_tx_last,
  output logic                    m_tx_valid,
  input  logic                    m_tx_ready,
  input  logic                    seq_clear,
  output logic                    len_err,
  output logic [15:0]             len_err_count
);

  localparam int C_DW_BITS = DATA_WIDTH * 8;
  localparam int C_NCONN   = 16;

  typedef enum logic [0:0] {
    ST_HDR = 1'b0,
    ST_PAY = 1'b1
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic                   w_slot_free;
  logic                   w_hdr_load;
  logic                   w_pay_acc;
  logic                   w_pkt_done;
  logic                   w_len_mis;
  logic [3:0]             r_conn;
  logic [12:0]            r_byte_num;
  logic [13:0]            r_acc;
  logic [13:0]            w_pop;
  logic [13:0]            w_acc_sum;
  logic [SEQ_WIDTH-1:0]   r_seq [C_NCONN];
  logic [C_DW_BITS-1:0]   w_hdr;

  // The output register can take a new beat when it is empty or being drained.
  assign w_slot_free = ~m_tx_valid | m_tx_ready;

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      w_pop = w_pop + {13'd0, s_tx_keep[i]};
    end
  end

  assign w_acc_sum  = r_acc + w_pop;
  assign w_pkt_done = w_pay_acc & s_tx_last;
  assign w_len_mis  = (w_acc_sum != {1'b0, r_byte_num});

  // Header is built from the live sideband since it is loaded in the same
  // cycle the sideband is latched.
  always_comb begin
    w_hdr                     = '0;
    w_hdr[3:0]                = s_tx_connection_id;
    w_hdr[20:8]               = s_tx_byte_num;
    w_hdr[31+SEQ_WIDTH:32]    = r_seq[s_tx_connection_id];
  end

  // Next-state / handshake logic. The header cycle never consumes the payload
  // beat; upstream only sees ready in the payload state.
  always_comb begin
    w_state_nxt = r_state;
    s_tx_ready  = 1'b0;
    w_hdr_load  = 1'b0;
    w_pay_acc   = 1'b0;
    case (r_state)
      ST_HDR: begin
        if (s_tx_valid && w_slot_free) begin
          w_hdr_load  = 1'b1;
          w_state_nxt = ST_PAY;
        end
      end
      ST_PAY: begin
        s_tx_ready = w_slot_free;
        if (s_tx_valid && w_slot_free) begin
          w_pay_acc = 1'b1;
          if (s_tx_last) begin
            w_state_nxt = ST_HDR;
          end
        end
      end
      default: w_state_nxt = ST_HDR;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_HDR;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Packet context and byte accumulator.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_conn     <= '0;
      r_byte_num <= '0;
      r_acc      <= '0;
    end else if (w_hdr_load) begin
      r_conn     <= s_tx_connection_id;
      r_byte_num <= s_tx_byte_num;
      r_acc      <= '0;
    end else if (w_pay_acc) begin
      r_acc <= w_acc_sum;
    end
  end

  // Output register stage.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_tx_valid <= 1'b0;
      m_tx_data  <= '0;
      m_tx_keep  <= '0;
      m_tx_last  <= 1'b0;
    end else if (w_hdr_load) begin
      m_tx_valid <= 1'b1;
      m_tx_data  <= w_hdr;
      m_tx_keep  <= '1;
      m_tx_last  <= 1'b0;
    end else if (w_pay_acc) begin
      m_tx_valid <= 1'b1;
      m_tx_data  <= s_tx_data;
      m_tx_keep  <= s_tx_keep;
      m_tx_last  <= s_tx_last;
    end else if (w_slot_free) begin
      m_tx_valid <= 1'b0;
    end
  end

  // Sequence counters; a clear pulse overrides a coincident increment.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < C_NCONN; i++) begin
        r_seq[i] <= '0;
      end
    end else if (seq_clear) begin
      for (int i = 0; i < C_NCONN; i++) begin
        r_seq[i] <= '0;
      end
    end else if (w_pkt_done) begin
      r_seq[r_conn] <= r_seq[r_conn] + 1'b1;
    end
  end

  // Length-error pulse and saturating counter.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      len_err       <= 1'b0;
      len_err_count <= '0;
    end else begin
      len_err <= w_pkt_done & w_len_mis;
      if (w_pkt_done && w_len_mis && (len_err_count != 16'hFFFF)) begin
        len_err_count <= len_err_count + 16'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tx_frame_header_inserter.sv
`default_nettype none
// ============================================================================
// Module   : tb_tx_frame_header_inserter
// Purpose  : Self-checking bench for tx_frame_header_inserter. A driver issues
//            packets and queues the expected framed beats; a monitor pops and
//            compares every accepted output beat and tracks len_err/count.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tx_frame_header_inserter;

  localparam int DW = 16;
  localparam int SW = 16;

  typedef struct packed {
    logic [DW*8-1:0] d;
    logic [DW-1:0]   k;
    logic            l;
  } beat_t;

  logic            clk = 1'b0;
  logic            resetn = 1'b0;
  logic [DW*8-1:0] s_tx_data = '0;
  logic [DW-1:0]   s_tx_keep = '0;
  logic [3:0]      s_tx_connection_id = '0;
  logic [12:0]     s_tx_byte_num = '0;
  logic            s_tx_last = 1'b0;
  logic            s_tx_valid = 1'b0;
  logic            s_tx_ready;
  logic [DW*8-1:0] m_tx_data;
  logic [DW-1:0]   m_tx_keep;
  logic            m_tx_last;
  logic            m_tx_valid;
  logic            m_tx_ready = 1'b1;
  logic            seq_clear = 1'b0;
  logic            len_err;
  logic [15:0]     len_err_count;

  tx_frame_header_inserter #(.DATA_WIDTH(DW), .SEQ_WIDTH(SW)) dut (
    .clk                (clk),
    .resetn             (resetn),
    .s_tx_data          (s_tx_data),
    .s_tx_keep          (s_tx_keep),
    .s_tx_connection_id (s_tx_connection_id),
    .s_tx_byte_num      (s_tx_byte_num),
    .s_tx_last          (s_tx_last),
    .s_tx_valid         (s_tx_valid),
    .s_tx_ready         (s_tx_ready),
    .m_tx_data          (m_tx_data),
    .m_tx_keep          (m_tx_keep),
    .m_tx_last          (m_tx_last),
    .m_tx_valid         (m_tx_valid),
    .m_tx_ready         (m_tx_ready),
    .seq_clear          (seq_clear),
    .len_err            (len_err),
    .len_err_count      (len_err_count)
  );

  always #5 clk = ~clk;

  int      total = 0;
  int      bad   = 0;
  beat_t   exp_q[$];
  int      model_seq [16];
  bit      cur_mis = 1'b0;
  int      rdy_mode = 0;   // 0: always ready, 1: random, 2: never ready

  // Monitor-side state.
  bit      exp_err = 1'b0;
  int      exp_cnt = 0;
  bit      have_prev = 1'b0;
  beat_t   prev_beat;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Downstream ready generator.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       m_tx_ready = 1'b1;
        1:       m_tx_ready = 1'($urandom_range(0, 1));
        default: m_tx_ready = 1'b0;
      endcase
    end
  end

  // Monitor: scoreboard pops, stall stability, len_err pulse and count.
  always @(negedge clk) begin
    if (!resetn) begin
      exp_err   = 1'b0;
      exp_cnt   = 0;
      have_prev = 1'b0;
    end else begin
      beat_t cur;
      cur = '{d: m_tx_data, k: m_tx_keep, l: m_tx_last};
      if (have_prev) begin
        check("stall_valid_held", {127'd0, m_tx_valid}, 128'd1);
        check("stall_beat_held", cur.d ^ prev_beat.d, 128'd0);
        check("stall_ctrl_held", {111'd0, cur.k, cur.l}, {111'd0, prev_beat.k, prev_beat.l});
      end
      have_prev = m_tx_valid && !m_tx_ready;
      prev_beat = cur;
      if (m_tx_valid && m_tx_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_beat: got data %h with empty queue", m_tx_data);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          check("beat_data", cur.d, e.d);
          check("beat_keep_last", {111'd0, cur.k, cur.l}, {111'd0, e.k, e.l});
        end
      end
      check("len_err", {127'd0, len_err}, {127'd0, exp_err});
      check("len_err_count", {112'd0, len_err_count}, 128'(exp_cnt));
      // Expectation for the next cycle from the upstream handshake now pending.
      if (s_tx_valid && s_tx_ready && s_tx_last) begin
        exp_err = cur_mis;
        if (cur_mis && exp_cnt != 65535) exp_cnt++;
      end else begin
        exp_err = 1'b0;
      end
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Sends one packet of nbytes real bytes declaring 'declared' bytes.
  task automatic send_pkt(input logic [3:0] conn, input int nbytes, input int declared, input bit clr);
    int     nb;
    int     rem;
    int     k;
    int     n;
    bit     acc;
    beat_t  h;
    logic [31:0] kw;
    logic [12:0] decl13;
    decl13 = declared[12:0];
    nb = (nbytes == 0) ? 1 : (nbytes + DW - 1) / DW;
    h = '0;
    h.d[3:0]   = conn;
    h.d[20:8]  = decl13;
    h.d[47:32] = 16'(model_seq[conn]);
    h.k = '1;
    h.l = 1'b0;
    exp_q.push_back(h);
    cur_mis = (nbytes != declared);
    s_tx_connection_id = conn;
    s_tx_byte_num      = decl13;
    rem = nbytes;
    for (int b = 0; b < nb; b++) begin
      beat_t e;
      k   = (rem > DW) ? DW : rem;
      rem = rem - k;
      kw  = (32'd1 << k) - 32'd1;
      e.d = {$urandom, $urandom, $urandom, $urandom};
      e.k = kw[DW-1:0];
      e.l = (b == nb - 1);
      exp_q.push_back(e);
      s_tx_data  = e.d;
      s_tx_keep  = e.k;
      s_tx_last  = e.l;
      s_tx_valid = 1'b1;
      n = 0;
      acc = 1'b0;
      do begin
        @(negedge clk);
        acc = s_tx_ready;
        if (acc && e.l && clr) seq_clear = 1'b1;
        @(posedge clk);
        #1;
        seq_clear = 1'b0;
        n++;
      end while (!acc && n < 2000);
      if (!acc) begin
        total++;
        bad++;
        $display("FAIL upstream_timeout: got no s_tx_ready after %0d cycles, expected acceptance", n);
        s_tx_valid = 1'b0;
        return;
      end
      // Sideband is only meaningful on the first beat; scramble it afterwards.
      s_tx_connection_id = 4'($urandom);
      s_tx_byte_num      = 13'($urandom);
    end
    s_tx_valid = 1'b0;
    s_tx_last  = 1'b0;
    if (clr) begin
      for (int i = 0; i < 16; i++) model_seq[i] = 0;
    end else begin
      model_seq[conn] = (model_seq[conn] + 1) % 65536;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 5000) begin
      tick(1);
      n++;
    end
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got %0d beats outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
    tick(3);
  endtask

  task automatic check_reset_state();
    @(negedge clk);
    check("rst_m_valid", {127'd0, m_tx_valid}, 128'd0);
    check("rst_s_ready", {127'd0, s_tx_ready}, 128'd0);
    check("rst_m_data", m_tx_data, 128'd0);
    check("rst_m_keep_last", {111'd0, m_tx_keep, m_tx_last}, 128'd0);
    check("rst_len_err", {127'd0, len_err}, 128'd0);
    check("rst_err_count", {112'd0, len_err_count}, 128'd0);
  endtask

  initial begin
    int nbytes;
    int decl;
    for (int i = 0; i < 16; i++) model_seq[i] = 0;
    tick(3);
    resetn = 1'b1;
    check_reset_state();
    tick(1);

    // Single packet, conn 3, 20 bytes.
    send_pkt(4'd3, 20, 20, 1'b0);
    drain();

    // Per-connection sequence numbers.
    send_pkt(4'd5, 16, 16, 1'b0);
    send_pkt(4'd5, 33, 33, 1'b0);
    send_pkt(4'd5, 5, 5, 1'b0);
    send_pkt(4'd2, 40, 40, 1'b0);
    drain();

    // Length mismatch: declared 32, actual 31.
    send_pkt(4'd1, 31, 32, 1'b0);
    drain();

    // Random downstream backpressure on a 4-beat packet.
    rdy_mode = 1;
    send_pkt(4'd4, 64, 64, 1'b0);
    drain();
    rdy_mode = 0;

    // Zero-length packet with an empty last beat.
    send_pkt(4'd6, 0, 0, 1'b0);
    drain();

    // seq_clear coincident with the last beat of conn 7's fifth packet.
    for (int i = 0; i < 4; i++) send_pkt(4'd7, 8, 8, 1'b0);
    send_pkt(4'd7, 8, 8, 1'b1);
    send_pkt(4'd7, 8, 8, 1'b0);
    drain();

    // Reset in the middle of a packet.
    rdy_mode = 2;
    tick(2);
    s_tx_connection_id = 4'd9;
    s_tx_byte_num      = 13'd16;
    s_tx_data          = {$urandom, $urandom, $urandom, $urandom};
    s_tx_keep          = '1;
    s_tx_last          = 1'b0;
    s_tx_valid         = 1'b1;
    tick(4);
    resetn     = 1'b0;
    s_tx_valid = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 16; i++) model_seq[i] = 0;
    tick(3);
    rdy_mode = 0;
    resetn   = 1'b1;
    check_reset_state();
    tick(1);
    send_pkt(4'd9, 16, 16, 1'b0);
    drain();

    // Randomised traffic.
    for (int p = 0; p < 30; p++) begin
      rdy_mode = $urandom_range(0, 1);
      nbytes   = $urandom_range(0, 70);
      decl     = nbytes;
      if ($urandom_range(0, 3) == 0) decl = nbytes + $urandom_range(1, 3);
      if ($urandom_range(0, 7) == 0) begin
        seq_clear = 1'b1;
        tick(1);
        seq_clear = 1'b0;
        for (int i = 0; i < 16; i++) model_seq[i] = 0;
      end
      send_pkt(4'($urandom_range(0, 15)), nbytes, decl, 1'b0);
    end
    rdy_mode = 0;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
